// File: rtl/password_checker_pkg.sv
// Shared constants and types for the door-lock keypad front end.
package lock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_CLR = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_ENT = 4'hB;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    UNLOCKED,
    LOCKED,
    SET_PW
  } lock_state_t;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/password_checker_if.sv
// Keypad event / lock status bundle; master is the keypad side, slave the checker.
interface password_checker_if #(
  parameter int PW_LEN = 4
);
  import lock_pkg::*;

  localparam int CNT_W = $clog2(PW_LEN + 2);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_code;
  logic               gen_stop;
  logic               gen_rst;
  logic               unlock;
  logic               lock_out;
  logic [CNT_W-1:0]   digit_cnt;

  modport master (
    output key_valid, key_code, gen_stop,
    input  gen_rst, unlock, lock_out, digit_cnt
  );

  modport slave (
    input  key_valid, key_code, gen_stop,
    output gen_rst, unlock, lock_out, digit_cnt
  );

endinterface

// File: rtl/password_checker_timer.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. the cycle it would expire.
module lock_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/password_checker.sv
// Keypad password checker: collects digits, compares on '#', drives unlock / gen_rst; frozen by gen_stop.
// Optional PW_CHANGE_EN macro adds SET_PW (new password entry from UNLOCKED); all outputs registered.
module password_checker
  import lock_pkg::*;
#(
  parameter int                      PW_LEN         = 4,
  parameter logic [4*PW_LEN-1:0]     DEFAULT_PW     = 16'h1234,
  parameter int                      UNLOCK_CYCLES  = 8,
  parameter int                      TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  password_checker_if.slave      bus
);

  localparam int PW_W  = DIGIT_W * PW_LEN;
  localparam int CW    = $clog2(PW_LEN + 2);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HLD_W = $clog2(UNLOCK_CYCLES + 1);

  lock_state_t      state;
  logic [PW_W-1:0]  entry_q;
  logic [CW-1:0]    cnt_q;
  logic [PW_W-1:0]  pw;
  logic             gen_rst_q;
  logic             unlock_q;
  logic             lock_out_q;
  logic             tmo_done;
  logic             hold_done;
  logic             key_digit;
  logic             match;

  assign key_digit = is_digit(bus.key_code);
  assign match     = (cnt_q == CW'(PW_LEN)) && (entry_q == pw);

  // Timers stay parked at their load value outside the states that consume them.
  lock_timer #(.WIDTH(TMO_W)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bus.key_valid || (state != ENTRY && state != SET_PW)),
    .load_val (TMO_W'(TIMEOUT_CYCLES)),
    .done     (tmo_done)
  );

  lock_timer #(.WIDTH(HLD_W)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state != UNLOCKED),
    .load_val (HLD_W'(UNLOCK_CYCLES)),
    .done     (hold_done)
  );

`ifdef PW_CHANGE_EN
  logic [PW_W-1:0] pw_q;
  assign pw = pw_q;
`else
  assign pw = DEFAULT_PW;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      entry_q    <= '0;
      cnt_q      <= '0;
      gen_rst_q  <= 1'b0;
      unlock_q   <= 1'b0;
      lock_out_q <= 1'b0;
`ifdef PW_CHANGE_EN
      pw_q       <= DEFAULT_PW;
`endif
    end else begin
      gen_rst_q  <= 1'b0;
      // Status levels follow the state one edge later.
      unlock_q   <= (state == UNLOCKED);
      lock_out_q <= (state == LOCKED);

      if (bus.gen_stop) begin
        state   <= LOCKED;
        entry_q <= '0;
        cnt_q   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.key_valid && key_digit) begin
              state   <= ENTRY;
              entry_q <= PW_W'(bus.key_code);
              cnt_q   <= CW'(1);
            end
          end

          ENTRY: begin
            if (bus.key_valid) begin
              if (key_digit) begin
                entry_q <= {entry_q[PW_W-DIGIT_W-1:0], bus.key_code};
                if (cnt_q != CW'(PW_LEN + 1)) cnt_q <= cnt_q + CW'(1);
              end else if (bus.key_code == KEY_CLR) begin
                state   <= IDLE;
                entry_q <= '0;
                cnt_q   <= '0;
              end else if (bus.key_code == KEY_ENT) begin
                if (match) begin
                  state <= UNLOCKED;
                end else begin
                  state     <= IDLE;
                  gen_rst_q <= 1'b1;
                end
                entry_q <= '0;
                cnt_q   <= '0;
              end
            end else if (tmo_done) begin
              state   <= IDLE;
              entry_q <= '0;
              cnt_q   <= '0;
            end
          end

          UNLOCKED: begin
            if (hold_done || (bus.key_valid && bus.key_code == KEY_CLR)) begin
              state <= IDLE;
`ifdef PW_CHANGE_EN
            end else if (bus.key_valid && bus.key_code == KEY_ENT) begin
              state   <= SET_PW;
              entry_q <= '0;
              cnt_q   <= '0;
`endif
            end
          end

`ifdef PW_CHANGE_EN
          SET_PW: begin
            if (bus.key_valid) begin
              if (key_digit) begin
                entry_q <= {entry_q[PW_W-DIGIT_W-1:0], bus.key_code};
                if (cnt_q != CW'(PW_LEN + 1)) cnt_q <= cnt_q + CW'(1);
              end else if (bus.key_code == KEY_CLR || bus.key_code == KEY_ENT) begin
                if (bus.key_code == KEY_ENT && cnt_q == CW'(PW_LEN)) pw_q <= entry_q;
                state   <= IDLE;
                entry_q <= '0;
                cnt_q   <= '0;
              end
            end else if (tmo_done) begin
              state   <= IDLE;
              entry_q <= '0;
              cnt_q   <= '0;
            end
          end
`endif

          LOCKED: begin
            state   <= IDLE;
            entry_q <= '0;
            cnt_q   <= '0;
          end

          default: begin
            state   <= IDLE;
            entry_q <= '0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.gen_rst   = gen_rst_q;
  assign bus.unlock    = unlock_q;
  assign bus.lock_out  = lock_out_q;
  assign bus.digit_cnt = cnt_q;

endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker: key-sequence table plus hand-written timing sequences.
module tb_password_checker;
  import lock_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  password_checker_if #(.PW_LEN(4)) bus ();

  password_checker #(
    .PW_LEN         (4),
    .DEFAULT_PW     (16'h1234),
    .UNLOCK_CYCLES  (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] keys;     // right-aligned, first key in the highest used nibble
    int          n;
    logic        exp_rst;
    logic        exp_unl;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic send_pw(input logic [15:0] pw);
    for (int k = 0; k < 4; k++) send(pw[4*(3-k) +: 4]);
    send(KEY_ENT);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    int   hi_cnt;
    int   rst_cnt;

    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.gen_stop  = 1'b0;

    vecs[0] = '{32'h0001234B, 5, 1'b0, 1'b1};  // correct password
    vecs[1] = '{32'h0001235B, 5, 1'b1, 1'b0};  // wrong last digit
    vecs[2] = '{32'h0012344B, 6, 1'b1, 1'b0};  // overflow
    vecs[3] = '{32'h0000123B, 4, 1'b1, 1'b0};  // too short
    vecs[4] = '{32'h0AB1234B, 7, 1'b0, 1'b1};  // '*' and '#' ignored in IDLE
    vecs[5] = '{32'h12A1234B, 8, 1'b0, 1'b1};  // clear mid-entry then retry
    vecs[6] = '{32'h0012D34B, 6, 1'b0, 1'b1};  // unused code ignored in ENTRY
    vecs[7] = '{32'h0000000B, 1, 1'b0, 1'b0};  // lone '#', no pulse
    vecs[8] = '{32'h0004321B, 5, 1'b1, 1'b0};  // reversed digits

    tick(2);
    chk("reset_gen_rst", 32'(bus.gen_rst), 32'd0);
    chk("reset_unlock", 32'(bus.unlock), 32'd0);
    chk("reset_lock_out", 32'(bus.lock_out), 32'd0);
    chk("reset_digit_cnt", 32'(bus.digit_cnt), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      do_reset();
      for (int k = 0; k < v.n; k++) send(v.keys[4*(v.n-1-k) +: 4]);
      chk($sformatf("vec%0d_gen_rst", i), 32'(bus.gen_rst), 32'(v.exp_rst));
      chk($sformatf("vec%0d_unlock_lat", i), 32'(bus.unlock), 32'd0);
      tick(1);
      chk($sformatf("vec%0d_unlock", i), 32'(bus.unlock), 32'(v.exp_unl));
      chk($sformatf("vec%0d_gen_rst_1cyc", i), 32'(bus.gen_rst), 32'd0);
      chk($sformatf("vec%0d_digit_cnt", i), 32'(bus.digit_cnt), 32'd0);
    end

    // Unlock hold length and no stray gen_rst.
    do_reset();
    send_pw(16'h1234);
    hi_cnt  = 0;
    rst_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (bus.unlock) hi_cnt++;
      if (bus.gen_rst) rst_cnt++;
    end
    chk("hold_cycles", 32'(hi_cnt), 32'd8);
    chk("hold_no_gen_rst", 32'(rst_cnt), 32'd0);

    // '*' ends the hold; unlock falls one edge later.
    do_reset();
    send_pw(16'h1234);
    tick(2);
    send(KEY_CLR);
    chk("clr_unlock_still", 32'(bus.unlock), 32'd1);
    tick(1);
    chk("clr_unlock_fall", 32'(bus.unlock), 32'd0);

    // Digit count saturates at PW_LEN+1.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      send(4'(k));
      if (k >= 3) chk($sformatf("sat_cnt_%0d", k), 32'(bus.digit_cnt), 32'((k > 5) ? 5 : k));
    end
    send(KEY_ENT);
    chk("sat_gen_rst", 32'(bus.gen_rst), 32'd1);

    // 16 idle cycles discard the entry.
    do_reset();
    send(4'd1);
    send(4'd2);
    tick(16);
    chk("tmo_cnt_cleared", 32'(bus.digit_cnt), 32'd0);
    send(4'd3);
    send(4'd4);
    send(KEY_ENT);
    chk("tmo_gen_rst", 32'(bus.gen_rst), 32'd1);
    tick(1);
    chk("tmo_no_unlock", 32'(bus.unlock), 32'd0);

    // 15 idle cycles: key arrives on the expiry cycle and wins.
    do_reset();
    send(4'd1);
    send(4'd2);
    tick(15);
    chk("tmo15_cnt_kept", 32'(bus.digit_cnt), 32'd2);
    send(4'd3);
    send(4'd4);
    send(KEY_ENT);
    chk("tmo15_no_gen_rst", 32'(bus.gen_rst), 32'd0);
    tick(1);
    chk("tmo15_unlock", 32'(bus.unlock), 32'd1);

    // gen_stop held during a full correct entry, then release and retry.
    do_reset();
    bus.gen_stop = 1'b1;
    tick(1);
    chk("stop_lock_out_lat", 32'(bus.lock_out), 32'd0);
    tick(1);
    chk("stop_lock_out", 32'(bus.lock_out), 32'd1);
    rst_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      send((k == 4) ? KEY_ENT : 4'(k + 1));
      if (bus.gen_rst) rst_cnt++;
    end
    tick(1);
    chk("stop_no_gen_rst", 32'(rst_cnt), 32'd0);
    chk("stop_no_unlock", 32'(bus.unlock), 32'd0);
    chk("stop_cnt", 32'(bus.digit_cnt), 32'd0);
    bus.gen_stop = 1'b0;
    tick(2);
    chk("stop_release", 32'(bus.lock_out), 32'd0);
    send_pw(16'h1234);
    tick(1);
    chk("stop_retry_unlock", 32'(bus.unlock), 32'd1);

    // '#' sampled together with gen_stop rising: wrong and right passwords.
    for (int w = 0; w < 2; w++) begin
      do_reset();
      send(4'd1);
      send(4'd2);
      send(4'd3);
      send((w == 0) ? 4'd5 : 4'd4);
      bus.key_valid = 1'b1;
      bus.key_code  = KEY_ENT;
      bus.gen_stop  = 1'b1;
      tick(1);
      bus.key_valid = 1'b0;
      chk($sformatf("race%0d_gen_rst", w), 32'(bus.gen_rst), 32'd0);
      tick(1);
      chk($sformatf("race%0d_unlock", w), 32'(bus.unlock), 32'd0);
      chk($sformatf("race%0d_lock_out", w), 32'(bus.lock_out), 32'd1);
      bus.gen_stop = 1'b0;
      tick(2);
    end

    // gen_stop during the hold drops unlock.
    do_reset();
    send_pw(16'h1234);
    tick(2);
    bus.gen_stop = 1'b1;
    tick(2);
    chk("hold_stop_unlock", 32'(bus.unlock), 32'd0);
    chk("hold_stop_lock_out", 32'(bus.lock_out), 32'd1);
    bus.gen_stop = 1'b0;
    tick(2);

    // Reset during the hold aborts it at the next edge.
    do_reset();
    send_pw(16'h1234);
    tick(3);
    chk("rst_hold_pre", 32'(bus.unlock), 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("rst_hold_unlock", 32'(bus.unlock), 32'd0);
    rst_n = 1'b1;

`ifdef PW_CHANGE_EN
    do_reset();
    send_pw(16'h1234);
    send(KEY_ENT);
    send_pw(16'h9876);
    chk("pwc_no_gen_rst", 32'(bus.gen_rst), 32'd0);
    send_pw(16'h9876);
    tick(1);
    chk("pwc_new_unlock", 32'(bus.unlock), 32'd1);
    send(KEY_CLR);
    tick(1);
    send_pw(16'h1234);
    chk("pwc_old_rejected", 32'(bus.gen_rst), 32'd1);
    do_reset();
    send_pw(16'h1234);
    tick(1);
    chk("pwc_reset_restores", 32'(bus.unlock), 32'd1);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/password_checker.md
# password_checker

Keypad-side front end of the door-lock datapath. Accepts decoded key events, assembles a digit sequence, compares it against the stored password on Enter, and either raises `unlock` or emits the one-cycle wrong-password pulse `gen_rst` consumed by `error_processer`. It obeys `gen_stop` from `error_processer`: while it is high, entry is frozen.

## Interface
- `PW_LEN`, 4: password length in decimal digits.
- `DEFAULT_PW`, 16'h1234: reset password, one BCD digit per nibble, first digit in the MS nibble; width `4*PW_LEN`.
- `UNLOCK_CYCLES`, 8: cycles `unlock` stays high.
- `TIMEOUT_CYCLES`, 16: maximum idle gap between keys during entry.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `key_valid` in 1: one key event per high cycle.
- `key_code` in 4: 0x0–0x9 digit, 0xA clear (`*`), 0xB enter (`#`), 0xC–0xF ignored.
- `gen_stop` in 1: lockout level from `error_processer`.
- `gen_rst` out 1: one-cycle pulse on wrong password.
- `unlock` out 1: door-open level.
- `lock_out` out 1: high while in LOCKED.
- `digit_cnt` out `$clog2(PW_LEN+2)`: digits captured, saturating at `PW_LEN+1`.

## Operation
- All outputs are registered. Reset values: `gen_rst`=0, `unlock`=0, `lock_out`=0, `digit_cnt`=0. Reset also clears the state to IDLE, clears the buffer, and sets the password to `DEFAULT_PW`.
- States and transitions:
  - IDLE: a digit moves to ENTRY. `*` and `#` with no digits are ignored, with no pulse.
  - ENTRY:
    - A digit shifts into the LS nibble of the buffer. `digit_cnt` increments and saturates at `PW_LEN+1`, which acts as the overflow marker.
    - `*` clears the buffer and count and returns to IDLE.
    - `#` compares the buffer. A match requires `digit_cnt==PW_LEN` and buffer equal to the password; this moves to UNLOCKED. Anything else pulses `gen_rst` and returns to IDLE.
    - No key for `TIMEOUT_CYCLES` cycles discards the entry and returns to IDLE without `gen_rst`.
  - UNLOCKED:
    - `unlock`=1; the hold counter runs.
    - When the counter expires, or on `*`, go to IDLE.
    - Digits are ignored.
    - `#` enters SET_PW only when the macro is defined; otherwise it is ignored.
  - LOCKED: entered from any state whenever `gen_stop`=1. Buffer and count are cleared, `unlock`=0, keys are ignored. On the first cycle `gen_stop`=0, go to IDLE.
- The buffer and `digit_cnt` are cleared on every return to IDLE.
- Simultaneous events:
  - `gen_stop` rising on the same cycle as `#`: `gen_stop` wins. No `gen_rst`, no unlock.
  - Timeout expiry on the same cycle as a valid key: the key wins and the timer reloads.

## Timing
- `#` sampled at edge N: `gen_rst` is high during cycle N→N+1 only, or `unlock` rises at edge N+1.
- `unlock` stays high for exactly `UNLOCK_CYCLES` cycles unless `*` or `gen_stop` ends it earlier. It falls at the edge after the terminating event.
- Each accepted key reloads the timeout counter to `TIMEOUT_CYCLES`. The timeout fires at the `TIMEOUT_CYCLES`-th consecutive cycle without `key_valid`.
- `gen_stop` sampled at edge N: `lock_out`=1 and `unlock`=0 from N+1.
- Asserting `rst_n` low mid-operation takes effect at the next edge. Any in-progress pulse or hold is aborted.

## Configuration
- `PW_CHANGE_EN` defined:
  - SET_PW state exists. Digits fill a shadow buffer.
  - `#` with exactly `PW_LEN` digits commits the new password and goes to IDLE.
  - Any other count, `*`, or a timeout aborts, keeps the old password, and goes to IDLE. No `gen_rst` is produced from SET_PW.
  - `gen_stop` overrides SET_PW as it does every other state.
- `PW_CHANGE_EN` undefined: the password is constant `DEFAULT_PW`, and `#` in UNLOCKED is ignored.

## Structure
- Shared package `lock_pkg`:
  - `KEY_CLR`=4'hA, `KEY_ENT`=4'hB.
  - State enum: IDLE, ENTRY, UNLOCKED, LOCKED, SET_PW.
  - Digit width constant 4.
- Sub-module `lock_timer`: loadable down-counter with a `done` flag, instantiated twice (inter-key timeout, unlock hold).

## Test plan
- Keys 1,2,3,4,`#` → `unlock`=1 one cycle after `#`, held for 8 cycles, then 0. `gen_rst` stays 0.
- Keys 1,2,3,5,`#` → single `gen_rst` pulse one cycle after `#`. `digit_cnt` returns to 0. Also keys 1,2,3,4,4,`#` (overflow) → `gen_rst` pulse.
- Keys 1,2, then 16 idle cycles, then 3,4,`#` → entry discarded, `gen_rst` pulse, no unlock.
- `gen_stop`=1 during keys 1,2,3,4,`#` → `lock_out`=1, no `gen_rst`, no unlock. Release `gen_stop`, then 1,2,3,4,`#` → unlock.
- `PW_CHANGE_EN`: unlock, `#`, then 9,8,7,6,`#` → 9,8,7,6,`#` unlocks and 1,2,3,4,`#` pulses `gen_rst`. `rst_n`=0 restores 1234.
- `#` sampled together with `gen_stop` rising → no `gen_rst`. `rst_n` low during an `unlock` hold → `unlock`=0 at the next edge.
